// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcode constants, ALU encodings and decode control types
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_ADDI = 11'h488;
  localparam logic [10:0] OP_SUBI = 11'h688;
  localparam logic [10:0] MASK_I  = 11'h7FE;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_B    = 11'h0A0;
  localparam logic [10:0] MASK_B  = 11'h7E0;
  localparam logic [10:0] OP_CBZ  = 11'h5A0;
  localparam logic [10:0] OP_CBNZ = 11'h5A8;
  localparam logic [10:0] MASK_CB = 11'h7F8;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [2:0] {IMM_NONE, IMM_B, IMM_CB, IMM_D, IMM_I} imm_sel_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       b;
    logic       cbz;
    logic       cbnz;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_match(logic [10:0] op, logic [10:0] value, logic [10:0] mask);
    return (op & mask) == value;
  endfunction

endpackage

// File: rtl/id_control.sv
// rtl/id_control.sv - combinational opcode decoder producing control flags and operand selects
module id_control
  import legv8_pkg::*;
(
  input  logic [10:0] op_i,
  output ctrl_t       ctrl_o,
  output imm_sel_t    imm_sel_o,
  output logic        uses_rs2_o,
  output logic        reg2loc_o
);

  always_comb begin
    ctrl_o     = '0;
    imm_sel_o  = IMM_NONE;
    uses_rs2_o = 1'b0;
    reg2loc_o  = 1'b0;
    if (op_i == OP_ADD || op_i == OP_SUB || op_i == OP_AND || op_i == OP_ORR) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_OP_FUNCT;
      uses_rs2_o       = 1'b1;
    end else if (op_match(op_i, OP_ADDI, MASK_I) || op_match(op_i, OP_SUBI, MASK_I)) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.alu_op    = ALU_OP_FUNCT;
      imm_sel_o        = IMM_I;
    end else if (op_i == OP_LDUR) begin
      ctrl_o.mem_read   = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.reg_write  = 1'b1;
      ctrl_o.alu_src    = 1'b1;
      ctrl_o.alu_op     = ALU_OP_ADD;
      imm_sel_o         = IMM_D;
    end else if (op_i == OP_STUR) begin
      ctrl_o.mem_write = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.alu_op    = ALU_OP_ADD;
      imm_sel_o        = IMM_D;
      uses_rs2_o       = 1'b1;
      reg2loc_o        = 1'b1;
    end else if (op_match(op_i, OP_B, MASK_B)) begin
      ctrl_o.b  = 1'b1;
      imm_sel_o = IMM_B;
    end else if (op_match(op_i, OP_CBZ, MASK_CB) || op_match(op_i, OP_CBNZ, MASK_CB)) begin
      // The two compare-branches differ only in op bit 3
      ctrl_o.cbz    = ~op_i[3];
      ctrl_o.cbnz   = op_i[3];
      ctrl_o.alu_op = ALU_OP_PASSB;
      imm_sel_o     = IMM_CB;
      uses_rs2_o    = 1'b1;
      reg2loc_o     = 1'b1;
    end else begin
      ctrl_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - LEGv8 decode stage: register file, immediates, load-use hazard, ID/EX register
module id_stage
  import legv8_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NREGS   = 32,
  parameter int RADDR_W = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [XLEN-1:0]    if_pc,
  input  logic [31:0]        if_instr,
  output logic               id_stall,
  input  logic               ex_flush,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [31:0]        ex_instr,
  output logic [XLEN-1:0]    ex_rdata1,
  output logic [XLEN-1:0]    ex_rdata2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [1:0]         ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_write,
  output logic               ex_b,
  output logic               ex_cbz,
  output logic               ex_cbnz,
  output logic               ex_illegal
);

  localparam logic [RADDR_W-1:0] ZR = RADDR_W'(NREGS - 1);

  ctrl_t               ctrl;
  imm_sel_t            imm_sel;
  logic                uses_rs2, reg2loc, hazard;
  logic [RADDR_W-1:0]  rs1, rs2;
  logic [XLEN-1:0]     rdata1, rdata2, imm;
  logic [XLEN-1:0]     rf_q [NREGS];

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     pc_q, pc_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [31:0]         instr_q, instr_d;
  logic [RADDR_W-1:0]  rd_q, rd_d;
  ctrl_t               ctrl_q, ctrl_d;

  id_control u_control (
    .op_i       (if_instr[31:21]),
    .ctrl_o     (ctrl),
    .imm_sel_o  (imm_sel),
    .uses_rs2_o (uses_rs2),
    .reg2loc_o  (reg2loc)
  );

  assign rs1 = if_instr[9:5];
  assign rs2 = reg2loc ? if_instr[4:0] : if_instr[20:16];

  always_comb begin
    case (imm_sel)
      IMM_B:   imm = {{(XLEN-26){if_instr[25]}}, if_instr[25:0]};
      IMM_CB:  imm = {{(XLEN-19){if_instr[23]}}, if_instr[23:5]};
      IMM_D:   imm = {{(XLEN-9){if_instr[20]}}, if_instr[20:12]};
      IMM_I:   imm = {{(XLEN-12){1'b0}}, if_instr[21:10]};
      default: imm = '0;
    endcase
  end

  // XZR reads as zero; a same-cycle write-back is forwarded so ID never sees stale data
  always_comb begin
    rdata1 = rf_q[rs1];
    rdata2 = rf_q[rs2];
    if (wb_we && wb_rd == rs1) rdata1 = wb_data;
    if (wb_we && wb_rd == rs2) rdata2 = wb_data;
    if (rs1 == ZR) rdata1 = '0;
    if (rs2 == ZR) rdata2 = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_rd != ZR) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign hazard   = if_valid & valid_q & ctrl_q.mem_read & (rd_q != ZR) &
                    ((rd_q == rs1) | (uses_rs2 & (rd_q == rs2)));
  assign id_stall = hazard & ~ex_flush;

  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    instr_d  = '0;
    rdata1_d = '0;
    rdata2_d = '0;
    imm_d    = '0;
    rd_d     = '0;
    ctrl_d   = '0;
    if (!ex_flush && !hazard) begin
      valid_d  = if_valid;
      pc_d     = if_pc;
      instr_d  = if_instr;
      rdata1_d = rdata1;
      rdata2_d = rdata2;
      imm_d    = imm;
      rd_d     = if_instr[4:0];
      ctrl_d   = ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      instr_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_instr      = instr_q;
  assign ex_rdata1     = rdata1_q;
  assign ex_rdata2     = rdata2_q;
  assign ex_imm        = imm_q;
  assign ex_rd         = rd_q;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_b          = ctrl_q.b;
  assign ex_cbz        = ctrl_q.cbz;
  assign ex_cbnz       = ctrl_q.cbnz;
  assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed table-driven and sequence checks for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [63:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        id_stall;
  logic        ex_flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [31:0] ex_instr;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic        ex_b, ex_cbz, ex_cbnz, ex_illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_stall(id_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_b(ex_b),
    .ex_cbz(ex_cbz), .ex_cbnz(ex_cbnz), .ex_illegal(ex_illegal)
  );

  wire [10:0] flags = {ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                       ex_reg_write, ex_b, ex_cbz, ex_cbnz, ex_illegal};

  localparam logic [10:0] F_R    = 11'b10_0_0_0_0_1_0_0_0_0;
  localparam logic [10:0] F_I    = 11'b10_1_0_0_0_1_0_0_0_0;
  localparam logic [10:0] F_LD   = 11'b00_1_1_0_1_1_0_0_0_0;
  localparam logic [10:0] F_ST   = 11'b00_1_0_1_0_0_0_0_0_0;
  localparam logic [10:0] F_B    = 11'b00_0_0_0_0_0_1_0_0_0;
  localparam logic [10:0] F_CBZ  = 11'b01_0_0_0_0_0_0_1_0_0;
  localparam logic [10:0] F_CBNZ = 11'b01_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] F_ILL  = 11'b00_0_0_0_0_0_0_0_0_1;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] flags;
    logic [63:0] imm;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic idle();
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    vecs[0]  = '{32'h910017E1, F_I,    64'h5};
    vecs[1]  = '{32'h8B010022, F_R,    64'h0};
    vecs[2]  = '{32'hCB030041, F_R,    64'h0};
    vecs[3]  = '{32'h8A030041, F_R,    64'h0};
    vecs[4]  = '{32'hAA030041, F_R,    64'h0};
    vecs[5]  = '{32'hD13FFC83, F_I,    64'hFFF};
    vecs[6]  = '{32'hF85FF0C5, F_LD,   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7]  = '{32'hF8010107, F_ST,   64'h10};
    vecs[8]  = '{32'h17FFFFFF, F_B,    64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{32'h14000123, F_B,    64'h123};
    vecs[10] = '{32'hB4FFFFC5, F_CBZ,  64'hFFFF_FFFF_FFFF_FFFE};
    vecs[11] = '{32'hB5000089, F_CBNZ, 64'h4};
    vecs[12] = '{32'h00000000, F_ILL,  64'h0};
    vecs[13] = '{32'h8B200000, F_ILL,  64'h0};

    // reset state
    #1;
    chk("rst_valid", 64'(ex_valid), 64'h0);
    chk("rst_stall", 64'(id_stall), 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);
    step();
    rst = 1'b0;

    // decode table, one idle cycle between vectors
    for (int i = 0; i < 14; i++) begin
      present(vecs[i].instr, 64'h1000 + 64'(i * 4));
      step();
      ins = vecs[i].instr;
      chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'h1);
      chk($sformatf("v%0d_flags", i), 64'(flags), 64'(vecs[i].flags));
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
      chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(ins[4:0]));
      chk($sformatf("v%0d_pc", i), ex_pc, 64'h1000 + 64'(i * 4));
      chk($sformatf("v%0d_instr", i), 64'(ex_instr), 64'(ins));
      idle();
      step();
    end

    // ADDI X1,XZR,#5 -> write-back X1=5 -> ADD X2,X1,X1
    present(32'h910017E1, 64'h2000);
    step();
    chk("addi_rdata1", ex_rdata1, 64'h0);
    idle();
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 64'h5;
    step();
    wb_we = 1'b0;
    present(32'h8B010022, 64'h2008);
    step();
    chk("add_rdata1", ex_rdata1, 64'h5);
    chk("add_rdata2", ex_rdata2, 64'h5);
    chk("add_aluop", 64'(ex_alu_op), 64'h2);

    // same-cycle write-back bypass: ADD X11,X10,X10 while X10<=0x77
    present(32'h8B0A014B, 64'h2010);
    wb_we = 1'b1; wb_rd = 5'd10; wb_data = 64'h77;
    step();
    wb_we = 1'b0;
    chk("bypass_rdata1", ex_rdata1, 64'h77);
    chk("bypass_rdata2", ex_rdata2, 64'h77);

    // write to XZR with a same-cycle read of X31
    present(32'h8B1F03E0, 64'h2014);
    wb_we = 1'b1; wb_rd = 5'd31; wb_data = 64'hDEAD;
    step();
    wb_we = 1'b0;
    chk("xzr_bypass", ex_rdata1, 64'h0);
    present(32'h8B1F03E0, 64'h2018);
    step();
    chk("xzr_read", ex_rdata2, 64'h0);

    // load-use: LDUR X3,[X1] then ADD X4,X3,X1
    present(32'hF8400023, 64'h3000);
    step();
    present(32'h8B010064, 64'h3004);
    #1;
    chk("lu_stall", 64'(id_stall), 64'h1);
    step();
    chk("lu_bubble_valid", 64'(ex_valid), 64'h0);
    chk("lu_bubble_flags", 64'(flags), 64'h0);
    chk("lu_stall_clear", 64'(id_stall), 64'h0);
    step();
    chk("lu_issue_valid", 64'(ex_valid), 64'h1);
    chk("lu_issue_pc", ex_pc, 64'h3004);
    chk("lu_issue_rdata2", ex_rdata2, 64'h5);

    // Reg2Loc: LDUR X3 then STUR X3,[X9] depends through instr[4:0]
    present(32'hF8400023, 64'h3010);
    step();
    present(32'hF8000123, 64'h3014);
    #1;
    chk("stur_stall", 64'(id_stall), 64'h1);
    step();
    // ADDI whose immediate bits alias rs2=X3 must not stall
    present(32'hF8400023, 64'h3020);
    step();
    present(32'h910300A4, 64'h3024);
    #1;
    chk("addi_nostall", 64'(id_stall), 64'h0);
    step();
    // load into XZR never creates a hazard
    present(32'hF840003F, 64'h3030);
    step();
    present(32'h8B1F03E0, 64'h3034);
    #1;
    chk("ldxzr_nostall", 64'(id_stall), 64'h0);
    step();

    // flush beats hazard
    present(32'hF8400023, 64'h4000);
    step();
    present(32'h8B010064, 64'h4004);
    ex_flush = 1'b1;
    #1;
    chk("flush_stall", 64'(id_stall), 64'h0);
    step();
    ex_flush = 1'b0;
    chk("flush_valid", 64'(ex_valid), 64'h0);
    chk("flush_flags", 64'(flags), 64'h0);

    // reset asserted mid-stall
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 64'h1234;
    step();
    wb_we = 1'b0;
    present(32'hF8400023, 64'h5000);
    step();
    present(32'h8B010064, 64'h5004);
    #1;
    chk("pre_rst_stall", 64'(id_stall), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(ex_valid), 64'h0);
    chk("rst_async_stall", 64'(id_stall), 64'h0);
    chk("rst_async_pc", ex_pc, 64'h0);
    step();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      present(32'h8B000000 | (32'(r) << 16) | (32'(r) << 5), 64'h6000);
      step();
      chk($sformatf("rst_x%0d_a", r), ex_rdata1, 64'h0);
      chk($sformatf("rst_x%0d_b", r), ex_rdata2, 64'h0);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
